// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts operation requests, decodes them into an
// ALU control code, drives registered operands into the ALU, waits a fixed
// latency, captures the result and returns it on a response channel.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | ready for a request; ALU inputs hold the last accepted operation
// EXEC  | operands driven to the ALU; latency counter running down to zero
// RESP  | response registers valid; waiting for RespReady
module alu_issue_ctrl #(
    parameter int ALU_LATENCY = 1,
    parameter int COUNT_W     = 16
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               ReqValid,
    output logic               ReqReady,
    input  logic [1:0]         ReqALUOp,
    input  logic [5:0]         ReqFunct,
    input  logic [31:0]        ReqA,
    input  logic [31:0]        ReqB,
    output logic [3:0]         ALUControl,
    output logic [31:0]        DataIn0,
    output logic [31:0]        DataIn1,
    input  logic [31:0]        DataOut,
    input  logic               ZeroOut,
    output logic               RespValid,
    input  logic               RespReady,
    output logic [31:0]        RespData,
    output logic               RespZero,
    output logic               RespErr,
    output logic [COUNT_W-1:0] OpCount
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;

    // Counter is loaded with latency-1 so that a zero count on entry to EXEC
    // means the result is captured on the very next edge.
    localparam logic [3:0] LAT_LOAD = 4'(ALU_LATENCY - 1);

    state_t     state;
    logic [3:0] lat_cnt;
    logic [3:0] dec_ctrl;
    logic       dec_illegal;

    // Ready only in IDLE, and forced low while reset is held.
    assign ReqReady = (state == ST_IDLE) && Reset_n;

    // Decode ALUOp/funct into the ALU control code and an illegal flag.
    always_comb begin
        dec_ctrl    = CTRL_AND;
        dec_illegal = 1'b0;
        unique case (ReqALUOp)
            2'b00: dec_ctrl = CTRL_ADD;
            2'b01: dec_ctrl = CTRL_SUB;
            2'b10: begin
                unique case (ReqFunct)
                    6'b100000: dec_ctrl = CTRL_ADD;
                    6'b100010: dec_ctrl = CTRL_SUB;
                    6'b100100: dec_ctrl = CTRL_AND;
                    6'b100101: dec_ctrl = CTRL_OR;
                    6'b101010: dec_ctrl = CTRL_SLT;
                    default:   dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Control FSM with registered ALU-side and response-side outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= ST_IDLE;
            lat_cnt    <= 4'd0;
            ALUControl <= CTRL_AND;
            DataIn0    <= 32'd0;
            DataIn1    <= 32'd0;
            RespValid  <= 1'b0;
            RespData   <= 32'd0;
            RespZero   <= 1'b0;
            RespErr    <= 1'b0;
            OpCount    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (ReqValid) begin
                        if (dec_illegal) begin
                            // Illegal ops never touch the ALU inputs.
                            RespData  <= 32'd0;
                            RespZero  <= 1'b0;
                            RespErr   <= 1'b1;
                            RespValid <= 1'b1;
                            state     <= ST_RESP;
                        end else begin
                            ALUControl <= dec_ctrl;
                            DataIn0    <= ReqA;
                            DataIn1    <= ReqB;
                            lat_cnt    <= LAT_LOAD;
                            state      <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (lat_cnt != 4'd0) begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end else begin
                        RespData  <= DataOut;
                        RespZero  <= ZeroOut;
                        RespErr   <= 1'b0;
                        RespValid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (RespReady) begin
                        RespValid <= 1'b0;
                        OpCount   <= OpCount + COUNT_W'(1);
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: a latency-1 instance exercises decode, data
// return, error handling and back-pressure; a latency-3 instance covers the
// longer latency and reset during EXEC. A behavioural ALU sits behind each.
module tb_alu_issue_ctrl;

    localparam int COUNT_W = 16;

    typedef struct packed {
        logic [31:0] data;
        logic        zero;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // latency-1 instance signals
    logic               rst_n;
    logic               req_valid;
    logic               req_ready;
    logic [1:0]         req_alu_op;
    logic [5:0]         req_funct;
    logic [31:0]        req_a, req_b;
    logic [3:0]         alu_ctrl;
    logic [31:0]        din0, din1, alu_data;
    logic               alu_zero;
    logic               resp_valid, resp_ready;
    logic [31:0]        resp_data;
    logic               resp_zero, resp_err;
    logic [COUNT_W-1:0] op_count;

    // latency-3 instance signals
    logic               rst3_n;
    logic               req_valid3;
    logic               req_ready3;
    logic [1:0]         req_alu_op3;
    logic [5:0]         req_funct3;
    logic [31:0]        req_a3, req_b3;
    logic [3:0]         alu_ctrl3;
    logic [31:0]        din0_3, din1_3, alu_data3;
    logic               alu_zero3;
    logic               resp_valid3, resp_ready3;
    logic [31:0]        resp_data3;
    logic               resp_zero3, resp_err3;
    logic [COUNT_W-1:0] op_count3;

    function automatic logic [32:0] alu_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (c)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = 32'hDEAD_BEEF;
        endcase
        return {(r == 32'd0), r};
    endfunction

    assign {alu_zero, alu_data}   = alu_model(alu_ctrl, din0, din1);
    assign {alu_zero3, alu_data3} = alu_model(alu_ctrl3, din0_3, din1_3);

    alu_issue_ctrl #(.ALU_LATENCY(1), .COUNT_W(COUNT_W)) dut (
        .Clk(clk), .Reset_n(rst_n),
        .ReqValid(req_valid), .ReqReady(req_ready),
        .ReqALUOp(req_alu_op), .ReqFunct(req_funct), .ReqA(req_a), .ReqB(req_b),
        .ALUControl(alu_ctrl), .DataIn0(din0), .DataIn1(din1),
        .DataOut(alu_data), .ZeroOut(alu_zero),
        .RespValid(resp_valid), .RespReady(resp_ready),
        .RespData(resp_data), .RespZero(resp_zero), .RespErr(resp_err),
        .OpCount(op_count)
    );

    alu_issue_ctrl #(.ALU_LATENCY(3), .COUNT_W(COUNT_W)) dut3 (
        .Clk(clk), .Reset_n(rst3_n),
        .ReqValid(req_valid3), .ReqReady(req_ready3),
        .ReqALUOp(req_alu_op3), .ReqFunct(req_funct3), .ReqA(req_a3), .ReqB(req_b3),
        .ALUControl(alu_ctrl3), .DataIn0(din0_3), .DataIn1(din1_3),
        .DataOut(alu_data3), .ZeroOut(alu_zero3),
        .RespValid(resp_valid3), .RespReady(resp_ready3),
        .RespData(resp_data3), .RespZero(resp_zero3), .RespErr(resp_err3),
        .OpCount(op_count3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst3_n = 1'b0;
        req_valid = 1'b0; req_alu_op = 2'b00; req_funct = 6'd0; req_a = 32'd0; req_b = 32'd0;
        resp_ready = 1'b0;
        req_valid3 = 1'b0; req_alu_op3 = 2'b00; req_funct3 = 6'd0; req_a3 = 32'd0; req_b3 = 32'd0;
        resp_ready3 = 1'b0;
        tick(); tick();
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready_low: got %b expected 0", req_ready);
        end
        checks++;
        if ({alu_ctrl, din0, din1, resp_valid, resp_data, resp_zero, resp_err, op_count} !== '0) begin
            errors++;
            $display("FAIL reset_values: ctrl=%h din0=%h din1=%h rv=%b rd=%h rz=%b re=%b cnt=%0d expected all zero",
                     alu_ctrl, din0, din1, resp_valid, resp_data, resp_zero, resp_err, op_count);
        end
        rst_n = 1'b1; rst3_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready_after_release: got %b expected 1", req_ready);
        end
        tick();
    endtask

    // One full transaction on the latency-1 instance, with optional back-pressure.
    task automatic run_op(input string name, input logic [1:0] op, input logic [5:0] fn,
                          input logic [31:0] a, input logic [31:0] b, input logic [3:0] ectrl,
                          input logic [31:0] edata, input logic ezero, input logic eerr,
                          input int exp_lat, input int hold);
        exp_t               e;
        exp_t               got;
        logic [3:0]         prev_ctrl;
        logic [3:0]         want_ctrl;
        logic [COUNT_W-1:0] prev_cnt;
        int                 lat;
        prev_ctrl = alu_ctrl;
        prev_cnt  = op_count;
        e.data = edata; e.zero = ezero; e.err = eerr;
        sb.push_back(e);
        req_alu_op = op; req_funct = fn; req_a = a; req_b = b;
        req_valid = 1'b1; resp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL %s_ready: got %b expected 1", name, req_ready);
        end
        tick();
        req_valid = 1'b0;
        want_ctrl = eerr ? prev_ctrl : ectrl;
        checks++;
        if (alu_ctrl !== want_ctrl) begin
            errors++; $display("FAIL %s_ctrl: got %b expected %b", name, alu_ctrl, want_ctrl);
        end
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== exp_lat) begin
            errors++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
        end
        got.data = resp_data; got.zero = resp_zero; got.err = resp_err;
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s_resp: got data=%h zero=%b err=%b expected data=%h zero=%b err=%b",
                     name, got.data, got.zero, got.err, e.data, e.zero, e.err);
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== e.data || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s_hold: got rv=%b data=%h ready=%b expected rv=1 data=%h ready=0",
                         name, resp_valid, resp_data, req_ready, e.data);
            end
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || op_count !== prev_cnt + COUNT_W'(1)) begin
            errors++;
            $display("FAIL %s_done: got rv=%b count=%0d expected rv=0 count=%0d",
                     name, resp_valid, op_count, prev_cnt + COUNT_W'(1));
        end
    endtask

    task automatic test_decode_data();
        run_op("add_funct", 2'b10, 6'b100000, 32'd1, 32'd2, 4'b0010, 32'd3, 1'b0, 1'b0, 1, 0);
        checks++;
        if (op_count !== 16'd1) begin
            errors++; $display("FAIL first_count: got %0d expected 1", op_count);
        end
        run_op("slt_neg", 2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd3, 4'b0111, 32'd1, 1'b0, 1'b0, 1, 0);
        run_op("slt_pos", 2'b10, 6'b101010, 32'd4, 32'd3, 4'b0111, 32'd0, 1'b1, 1'b0, 1, 0);
        run_op("and", 2'b10, 6'b100100, 32'hF0F0_1234, 32'h0FF0_FFFF, 4'b0000, 32'h00F0_1234, 1'b0, 1'b0, 1, 0);
        run_op("or", 2'b10, 6'b100101, 32'hF000_0000, 32'h0000_000F, 4'b0001, 32'hF000_000F, 1'b0, 1'b0, 1, 0);
        run_op("sub_funct", 2'b10, 6'b100010, 32'd10, 32'd3, 4'b0110, 32'd7, 1'b0, 1'b0, 1, 0);
        run_op("beq_eq", 2'b01, 6'b111111, 32'd4, 32'd4, 4'b0110, 32'd0, 1'b1, 1'b0, 1, 0);
        run_op("beq_ne", 2'b01, 6'b000000, 32'd4, 32'd3, 4'b0110, 32'd1, 1'b0, 1'b0, 1, 0);
    endtask

    task automatic test_illegal();
        logic [31:0] prev_din0;
        prev_din0 = din0;
        run_op("bad_funct", 2'b10, 6'b000000, 32'd9, 32'd9, 4'b0000, 32'd0, 1'b0, 1'b1, 0, 1);
        run_op("aluop11", 2'b11, 6'b100000, 32'd5, 32'd5, 4'b0000, 32'd0, 1'b0, 1'b1, 0, 0);
        checks++;
        if (din0 !== prev_din0) begin
            errors++; $display("FAIL illegal_din0: got %h expected %h", din0, prev_din0);
        end
    endtask

    task automatic test_back_to_back();
        exp_t               e;
        logic [COUNT_W-1:0] prev_cnt;
        int                 lat;
        prev_cnt = op_count;
        e.data = 32'h8000_0002; e.zero = 1'b0; e.err = 1'b0;
        sb.push_back(e);
        req_alu_op = 2'b00; req_funct = 6'd0; req_a = 32'h8000_0001; req_b = 32'd1;
        req_valid = 1'b1; resp_ready = 1'b0;
        tick();
        // requester now presents and holds a second request
        req_a = 32'd5; req_b = 32'd6;
        e.data = 32'd11;
        sb.push_back(e);
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        e = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== e.data || req_ready !== 1'b0 || din0 !== 32'h8000_0001) begin
                errors++;
                $display("FAIL b2b_hold%0d: got rv=%b data=%h ready=%b din0=%h expected rv=1 data=%h ready=0 din0=80000001",
                         i, resp_valid, resp_data, req_ready, din0, e.data);
            end
            tick();
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || din0 !== 32'h8000_0001 || op_count !== prev_cnt + COUNT_W'(1)) begin
            errors++;
            $display("FAIL b2b_release: got rv=%b ready=%b din0=%h count=%0d expected rv=0 ready=1 din0=80000001 count=%0d",
                     resp_valid, req_ready, din0, op_count, prev_cnt + COUNT_W'(1));
        end
        tick();
        req_valid = 1'b0;
        checks++;
        if (din0 !== 32'd5 || din1 !== 32'd6 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_accept: got din0=%h din1=%h ready=%b expected din0=5 din1=6 ready=0",
                     din0, din1, req_ready);
        end
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        e = sb.pop_front();
        checks++;
        if (resp_data !== e.data || lat !== 1) begin
            errors++;
            $display("FAIL b2b_second_resp: got data=%h lat=%0d expected data=%h lat=1", resp_data, lat, e.data);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_latency3_and_reset();
        int lat;
        req_alu_op3 = 2'b00; req_a3 = 32'd100; req_b3 = 32'd23; req_valid3 = 1'b1;
        tick();
        req_valid3 = 1'b0;
        lat = 0;
        while (resp_valid3 !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== 3 || resp_data3 !== 32'd123) begin
            errors++; $display("FAIL lat3_resp: got lat=%0d data=%h expected lat=3 data=0000007b", lat, resp_data3);
        end
        resp_ready3 = 1'b1;
        tick();
        resp_ready3 = 1'b0;
        checks++;
        if (op_count3 !== 16'd1) begin
            errors++; $display("FAIL lat3_count: got %0d expected 1", op_count3);
        end
        // reset pulsed while the next operation is in EXEC
        req_a3 = 32'd7; req_b3 = 32'd8; req_valid3 = 1'b1;
        tick();
        req_valid3 = 1'b0;
        tick();
        rst3_n = 1'b0;
        #1;
        checks++;
        if ({alu_ctrl3, din0_3, din1_3, resp_valid3, resp_data3, resp_err3, op_count3, req_ready3} !== '0) begin
            errors++;
            $display("FAIL midop_reset: ctrl=%h din0=%h din1=%h rv=%b rd=%h re=%b cnt=%0d ready=%b expected all zero",
                     alu_ctrl3, din0_3, din1_3, resp_valid3, resp_data3, resp_err3, op_count3, req_ready3);
        end
        #2;
        rst3_n = 1'b1;
        resp_ready3 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (resp_valid3 !== 1'b0 || op_count3 !== 16'd0) begin
                errors++;
                $display("FAIL midop_no_resp%0d: got rv=%b count=%0d expected rv=0 count=0", i, resp_valid3, op_count3);
            end
        end
        resp_ready3 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode_data();
        test_illegal();
        test_back_to_back();
        test_latency3_and_reset();
        checks++;
        if (op_count !== 16'd12) begin
            errors++; $display("FAIL final_count: got %0d expected 12", op_count);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Initiator side of the ALU interface. It accepts operation requests (ALUOp/funct plus two operands) over a valid/ready handshake and decodes them into the 4-bit ALUControl code. It drives registered operands into the ALU, waits a fixed latency, then captures DataOut/ZeroOut. It returns the result on a valid/ready response channel and sits between the datapath control FSM and the ALU.

Parameters:
ALU_LATENCY, 1, cycles from ALU inputs being driven to result capture; legal range 1..15.
COUNT_W, 16, width of the completed-operation counter.

Ports:
Clk  input  1  clock; all flops rising-edge.
Reset_n  input  1  asynchronous active-low reset.
ReqValid  input  1  request present.
ReqReady  output  1  block can accept a request.
ReqALUOp  input  2  00=add, 01=sub/beq, 10=R-type (use funct), 11=reserved.
ReqFunct  input  6  R-type funct field.
ReqA  input  32  operand A.
ReqB  input  32  operand B.
ALUControl  output  4  to ALU: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
DataIn0  output  32  to ALU operand 0.
DataIn1  output  32  to ALU operand 1.
DataOut  input  32  ALU result.
ZeroOut  input  1  ALU zero flag.
RespValid  output  1  response present.
RespReady  input  1  consumer accepts the response.
RespData  output  32  captured result.
RespZero  output  1  captured zero flag.
RespErr  output  1  illegal operation flag.
OpCount  output  COUNT_W  number of completed responses.

Behaviour:
- Reset (asynchronous, Reset_n=0): state=IDLE; ReqReady=0 while reset is asserted and 1 in the first IDLE cycle after release.
- Reset values: ALUControl=0000, DataIn0=DataIn1=0, RespValid=0, RespData=0, RespZero=0, RespErr=0, OpCount=0, latency counter=0.
- Reset mid-operation: any in-flight operation is dropped and no response is produced.
- FSM states: IDLE, EXEC, RESP.
- ReqReady=1 only in IDLE. The handshake completes on a rising edge with ReqValid&&ReqReady.
- Decode at acceptance:
  - ALUOp 00 -> 0010.
  - ALUOp 01 -> 0110.
  - ALUOp 10 with funct 100000 -> 0010; 100010 -> 0110; 100100 -> 0000; 100101 -> 0001; 101010 -> 0111.
  - Any other funct, or ALUOp 11, is illegal.
- IDLE, legal request accepted: register ALUControl, DataIn0=ReqA, DataIn1=ReqB; load counter=ALU_LATENCY-1; go to EXEC.
- IDLE, illegal request accepted: ALU outputs unchanged; RespData=0, RespZero=0, RespErr=1, RespValid=1; go to RESP. No EXEC cycles occur.
- EXEC:
  - counter!=0: decrement the counter.
  - counter==0: capture RespData=DataOut, RespZero=ZeroOut, RespErr=0; set RespValid=1; go to RESP.
- Latency: RespValid rises exactly ALU_LATENCY cycles after the accepting edge for legal ops, and 0 cycles (next cycle) for illegal ops.
- ALU inputs (ALUControl, DataIn0, DataIn1) hold stable throughout EXEC and RESP, and until the next acceptance.
- RESP:
  - RespValid, RespData, RespZero and RespErr hold stable while RespReady=0.
  - On RespValid&&RespReady: RespValid=0, OpCount+=1 (wraps modulo 2^COUNT_W, illegal ops included), go to IDLE.
- RespReady asserted outside RESP is ignored.
- A request arriving during EXEC/RESP is not accepted; the requester holds it.
- Throughput: best case one op per ALU_LATENCY+2 cycles.
- Arithmetic is performed by the ALU only; this block performs no arithmetic on data.

Test Plan:
- Reset, then ALUOp=10, funct=100000, A=1, B=2, RespReady=1 -> ALUControl=0010, RespValid one cycle after accept, RespData=3, RespZero=0, OpCount=1.
- ALUOp=10, funct=101010, A=0xFFFFFFFF, B=3 -> ALUControl=0111, RespData=1. Then A=4, B=3 -> RespData=0.
- ALUOp=01, A=4, B=4 -> ALUControl=0110, RespZero=1. Then A=4, B=3 -> RespZero=0, RespData=1.
- ALUOp=10, funct=000000, and separately ALUOp=11 -> RespErr=1, RespData=0, RespValid on the next cycle, ALUControl unchanged, OpCount still increments.
- RespReady held low 3 cycles with ReqValid held high (A=0x80000001, B=1, add) -> RespData=0x80000002 stable, ReqReady=0 throughout, second request accepted only after the response handshake.
- ALU_LATENCY=3: RespValid exactly 3 cycles after accept. Reset_n pulsed low during EXEC -> all outputs at reset values immediately, no response after release, OpCount=0.
